q3_fsm: RTL and testbench

Q3_FSM -- requirements
Module: q3_fsm

---
 rtl/q3_fsm_pkg.sv | 16 +
 rtl/q3_fsm.sv | 38 +++
 tb/tb_q3_fsm.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/q3_fsm_pkg.sv
// Shared state encoding for the q3_fsm window detector.
// S<i><j>: i bits of the current 3-bit window seen, j of them equal to 1.
package q3_fsm_pkg;

  typedef enum logic [2:0] {
    A   = 3'd0,
    B   = 3'd1,
    C   = 3'd2,
    S10 = 3'd3,
    S11 = 3'd4,
    S20 = 3'd5,
    S21 = 3'd6,
    S22 = 3'd7
  } state_t;

endpackage

// File: rtl/q3_fsm.sv
// Moore FSM: after a start request, flags every non-overlapping 3-cycle
// window of w that holds exactly two 1s (z high for one cycle, in state C).
module q3_fsm
  import q3_fsm_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic s,
  input  logic w,
  output logic z
);

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= A;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = A;
    case (state)
      A:       state_nxt = s ? B : A;
      B, C:    state_nxt = w ? S11 : S10;
      S10:     state_nxt = w ? S21 : S20;
      S11:     state_nxt = w ? S22 : S21;
      // Two zeros already seen: the window cannot qualify, third bit ignored.
      S20:     state_nxt = B;
      S21:     state_nxt = w ? C : B;
      S22:     state_nxt = w ? B : C;
      default: state_nxt = A;
    endcase
  end

  assign z = (state == C);

endmodule

// File: tb/tb_q3_fsm.sv
// Directed and randomised checks of the q3_fsm window detector.
module tb_q3_fsm;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic s = 1'b0;
  logic w = 1'b0;
  logic z;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  q3_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (s),
    .w       (w),
    .z       (z)
  );

  // Drive inputs, let one rising edge sample them, settle 1ns past the edge.
  task automatic tick(input logic sv, input logic wv);
    s = sv;
    w = wv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    s = 1'b0;
    w = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    checks++;
    if (z !== 1'b0) begin
      failures++;
      $display("FAIL reset_async z=%b expected=0", z);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (z !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d z=%b expected=0", i, z);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (z !== 1'b0) begin
        failures++;
        $display("FAIL idle_s0 cycle=%0d z=%b expected=0", i, z);
      end
    end
    // Still idle: a qualifying w pattern without s must not pulse.
    begin
      logic [2:0] wv;
      wv = 3'b110;
      for (int i = 0; i < 3; i++) begin
        tick(1'b0, wv[2-i]);
        checks++;
        if (z !== 1'b0) begin
          failures++;
          $display("FAIL idle_ignores_w cycle=%0d z=%b expected=0", i, z);
        end
      end
    end
  endtask

  task automatic test_single_window;
    logic [5:0] wv;
    logic [5:0] ev;
    do_reset();
    tick(1'b1, 1'b0);
    checks++;
    if (z !== 1'b0) begin
      failures++;
      $display("FAIL start z=%b expected=0", z);
    end
    wv = 6'b110_000;
    ev = 6'b001_000;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, wv[5-i]);
      checks++;
      if (z !== ev[5-i]) begin
        failures++;
        $display("FAIL single_window cycle=%0d z=%b expected=%b", i, z, ev[5-i]);
      end
    end
  endtask

  task automatic test_windows;
    logic [11:0] wv;
    logic [11:0] ev;
    do_reset();
    tick(1'b1, 1'b0);
    wv = 12'b101_011_111_001;
    ev = 12'b001_001_000_000;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, wv[11-i]);
      checks++;
      if (z !== ev[11-i]) begin
        failures++;
        $display("FAIL windows cycle=%0d z=%b expected=%b", i, z, ev[11-i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] wv;
    logic [8:0] ev;
    logic [8:0] sv;
    do_reset();
    tick(1'b1, 1'b0);
    wv = 9'b110_110_011;
    ev = 9'b001_001_001;
    sv = 9'b000_000_111;
    for (int i = 0; i < 9; i++) begin
      tick(sv[8-i], wv[8-i]);
      checks++;
      if (z !== ev[8-i]) begin
        failures++;
        $display("FAIL back_to_back cycle=%0d z=%b expected=%b", i, z, ev[8-i]);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [2:0] wv;
    logic [2:0] ev;
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    checks++;
    if (z !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_pulse z=%b expected=1", z);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (z !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_z z=%b expected=0", z);
    end
    #1;
    reset_n = 1'b1;
    wv = 3'b110;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, wv[2-i]);
      checks++;
      if (z !== 1'b0) begin
        failures++;
        $display("FAIL after_reset_idle cycle=%0d z=%b expected=0", i, z);
      end
    end
    // Reset partway through a window; a fresh window must start from scratch.
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick(1'b1, 1'b0);
    wv = 3'b011;
    ev = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, wv[2-i]);
      checks++;
      if (z !== ev[2-i]) begin
        failures++;
        $display("FAIL mid_window_reset cycle=%0d z=%b expected=%b", i, z, ev[2-i]);
      end
    end
  endtask

  task automatic test_random;
    bit started;
    int cnt;
    int ones;
    logic zexp;
    logic sv;
    logic wv;
    do_reset();
    started = 1'b0;
    cnt = 0;
    ones = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(39) == 0) begin
        reset_n = 1'b0;
        #1;
        checks++;
        if (z !== 1'b0) begin
          failures++;
          $display("FAIL random_reset cycle=%0d z=%b expected=0", i, z);
        end
        reset_n = 1'b1;
        started = 1'b0;
      end
      sv = ($urandom_range(7) == 0);
      wv = 1'($urandom_range(1));
      tick(sv, wv);
      zexp = 1'b0;
      if (!started) begin
        if (sv) begin
          started = 1'b1;
          cnt = 0;
          ones = 0;
        end
      end else begin
        cnt++;
        ones += int'(wv);
        if (cnt == 3) begin
          zexp = (ones == 2);
          cnt = 0;
          ones = 0;
        end
      end
      checks++;
      if (z !== zexp) begin
        failures++;
        $display("FAIL random cycle=%0d z=%b expected=%b", i, z, zexp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_windows();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
